// File: rtl/conv2d_rail_sequencer_pkg.sv
// Shared sizing, state encoding and error codes for the conv2d dual-rail sequencer.
package conv2d_rail_sequencer_pkg;

  localparam int BIT_DATA_DEF = 8;
  localparam int KSIZE_DEF    = 9;
  localparam int BIT_Y_DEF    = 2 * BIT_DATA_DEF + $clog2(KSIZE_DEF - 1);
  localparam int TIMEOUT_DEF  = 1023;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    RTZ_IN,
    WAIT_Y,
    ACK,
    RTZ_OUT,
    HOLD,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

endpackage

// File: rtl/conv2d_rail_sequencer_rail_sync_detect.sv
// Two-flop synchroniser for a dual-rail bus with completion, spacer and
// illegal-code detection; completion and spacer need two matching samples.
module rail_sync_detect #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] t,
  input  logic [W-1:0] f,
  output logic [W-1:0] sync_t,
  output logic         complete,
  output logic         spacer,
  output logic         illegal
);

  logic [W-1:0] t_meta, f_meta, t_sync, f_sync, t_prev, f_prev;

  // NOTE: these flops are reset so rails left over from before a reset can
  // never masquerade as a stable completion or spacer afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_meta <= '0;
      f_meta <= '0;
      t_sync <= '0;
      f_sync <= '0;
      t_prev <= '0;
      f_prev <= '0;
    end else begin
      t_meta <= t;
      f_meta <= f;
      t_sync <= t_meta;
      f_sync <= f_meta;
      t_prev <= t_sync;
      f_prev <= f_sync;
    end
  end

  assign sync_t   = t_sync;
  assign complete = (&(t_sync ^ f_sync)) && (t_sync == t_prev) && (f_sync == f_prev);
  assign spacer   = ~|{t_sync, f_sync, t_prev, f_prev};
  assign illegal  = |(t_sync & f_sync);

endmodule

// File: rtl/conv2d_rail_sequencer.sv
// Clocked valid/ready front end that drives one asynchronous dual-rail
// kernel_conv2d through its 4-phase input and output handshakes.
module conv2d_rail_sequencer
  import conv2d_rail_sequencer_pkg::*;
#(
  parameter int BIT_DATA = BIT_DATA_DEF,
  parameter int KSIZE    = KSIZE_DEF,
  parameter int BIT_Y    = 2 * BIT_DATA + $clog2(KSIZE - 1),
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [KSIZE*BIT_DATA-1:0] x,
  input  logic [KSIZE*BIT_DATA-1:0] w,
  output logic [KSIZE*BIT_DATA-1:0] k_xt,
  output logic [KSIZE*BIT_DATA-1:0] k_xf,
  output logic [KSIZE*BIT_DATA-1:0] k_w,
  input  logic                      k_ack_prev,
  input  logic [BIT_Y-1:0]          k_yt,
  input  logic [BIT_Y-1:0]          k_yf,
  output logic                      k_ack_nxt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [BIT_Y-1:0]   y,
  output logic                      y_neg,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [TW-1:0]  timer;
  logic           ack_meta, ack_sync;
  logic [BIT_Y-1:0] y_sync;
  logic           y_complete, y_spacer, y_illegal;
  logic           counting, timeout_hit, illegal_hit;

  rail_sync_detect #(.W(BIT_Y)) u_y_sync (
    .clk      (clk),
    .reset    (reset),
    .t        (k_yt),
    .f        (k_yf),
    .sync_t   (y_sync),
    .complete (y_complete),
    .spacer   (y_spacer),
    .illegal  (y_illegal)
  );

  assign counting    = state inside {SEND, RTZ_IN, WAIT_Y, ACK};
  assign timeout_hit = counting && (timer == TW'(TIMEOUT));
  assign illegal_hit = (state == WAIT_Y || state == ACK) && y_illegal;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      ack_meta  <= 1'b0;
      ack_sync  <= 1'b0;
      in_ready  <= 1'b0;
      k_xt      <= '0;
      k_xf      <= '0;
      k_w       <= '0;
      k_ack_nxt <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      y_neg     <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      ack_meta <= k_ack_prev;
      ack_sync <= ack_meta;
      // Timer returns to zero on any state change; only waiting states count.
      timer    <= '0;
      if (illegal_hit || timeout_hit) begin
        state     <= ERR;
        err       <= 1'b1;
        err_code  <= (illegal_hit ? ERR_ILLEGAL : ERR_NONE) |
                     (timeout_hit ? ERR_TIMEOUT : ERR_NONE);
        in_ready  <= 1'b0;
        k_xt      <= '0;
        k_xf      <= '0;
        k_w       <= '0;
        k_ack_nxt <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_ready && in_valid) begin
              in_ready <= 1'b0;
              k_xt     <= x;
              k_xf     <= ~x;
              k_w      <= w;
              state    <= SEND;
            end else begin
              in_ready <= 1'b1;
            end
          end
          SEND: begin
            if (ack_sync) begin
              k_xt  <= '0;
              k_xf  <= '0;
              state <= RTZ_IN;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          RTZ_IN: begin
            if (!ack_sync) state <= WAIT_Y;
            else           timer <= timer + TW'(1);
          end
          WAIT_Y: begin
            if (y_complete) begin
              y         <= y_sync;
              y_neg     <= y_sync[BIT_Y-1];
              k_ack_nxt <= 1'b1;
              state     <= ACK;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ACK: begin
            if (y_spacer) begin
              k_ack_nxt <= 1'b0;
              state     <= RTZ_OUT;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          RTZ_OUT: begin
            out_valid <= 1'b1;
            state     <= HOLD;
          end
          HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= ERR;
        endcase
      end
    end
  end

endmodule
